wb_regfile: RTL



---
 rtl/wb_regfile.sv | 82 ++++++++
 1 files changed

// File: rtl/wb_regfile.sv
// Writeback-side register file: writeback mux, 32-entry GPR array with
// hardwired zero register, two combinational read ports and a retire counter.
// Optional same-cycle write-to-read bypass: define WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WB_MemtoReg,
    input  logic              WB_RegWrite,
    input  logic [ADDR_W-1:0] WB_RegDst,
    input  logic [DATA_W-1:0] WB_ReadData,
    input  logic [DATA_W-1:0] WB_ALUResult,
    input  logic [ADDR_W-1:0] ID_Rs,
    input  logic [ADDR_W-1:0] ID_Rt,
    output logic [DATA_W-1:0] ID_ReadData1,
    output logic [DATA_W-1:0] ID_ReadData2,
    output logic [DATA_W-1:0] WB_WriteData,
    output logic [31:0]       WB_RetireCount
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [31:0]       retire_count_q;
    logic [31:0]       retire_count_d;
    logic              commit;

    always_comb begin
        WB_WriteData = WB_MemtoReg ? WB_ReadData : WB_ALUResult;
        commit       = WB_RegWrite && (WB_RegDst != '0);
    end

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_comb begin
        regs_d         = regs_q;
        retire_count_d = retire_count_q;
        if (commit) begin
            regs_d[WB_RegDst] = WB_WriteData;
            retire_count_d    = retire_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q         <= '{default: '0};
            retire_count_q <= '0;
        end else begin
            regs_q         <= regs_d;
            retire_count_q <= retire_count_d;
        end
    end

    always_comb begin
        ID_ReadData1 = '0;
        if (ID_Rs != '0) begin
            ID_ReadData1 = regs_q[ID_Rs];
`ifdef WB_REGFILE_BYPASS_EN
            if (commit && (ID_Rs == WB_RegDst)) begin
                ID_ReadData1 = WB_WriteData;
            end
`endif
        end
    end

    always_comb begin
        ID_ReadData2 = '0;
        if (ID_Rt != '0) begin
            ID_ReadData2 = regs_q[ID_Rt];
`ifdef WB_REGFILE_BYPASS_EN
            if (commit && (ID_Rt == WB_RegDst)) begin
                ID_ReadData2 = WB_WriteData;
            end
`endif
        end
    end

    assign WB_RetireCount = retire_count_q;

endmodule
